// File: rtl/asc2hex_pkg.sv
// Shared ASCII constants and parser state encoding for the console hex parsers.
package asc2hex_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_UA    = 8'h41;
    localparam logic [7:0] ASCII_UF    = 8'h46;
    localparam logic [7:0] ASCII_LA    = 8'h61;
    localparam logic [7:0] ASCII_LF    = 8'h66;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_NL    = 8'h0A;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SKIP  = 2'd2
    } state_e;

endpackage

// File: rtl/asc2hex_asc2nib.sv
// Combinational ASCII character classifier: hex nibble value, hex flag, delimiter flag.
module asc2nib
    import asc2hex_pkg::*;
(
    input  logic [7:0] din,
    output logic [3:0] nib,
    output logic       is_hex,
    output logic       is_delim
);

    logic is_dig;
    logic is_uc;
    logic is_lc;

    always_comb begin
        is_dig   = (din >= ASCII_0)  && (din <= ASCII_9);
        is_uc    = (din >= ASCII_UA) && (din <= ASCII_UF);
        is_lc    = (din >= ASCII_LA) && (din <= ASCII_LF);
        is_hex   = is_dig || is_uc || is_lc;
        is_delim = (din == ASCII_SP) || (din == ASCII_CR) ||
                   (din == ASCII_NL) || (din == ASCII_COMMA);
        nib = 4'd0;
        if (is_dig) begin
            nib = 4'(din - ASCII_0);
        end else if (is_uc) begin
            nib = 4'(din - ASCII_UA + 8'd10);
        end else if (is_lc) begin
            nib = 4'(din - ASCII_LA + 8'd10);
        end
    end

endmodule

// File: rtl/asc2hex.sv
// ASCII hex token parser: accumulates hex digits, emits value on a delimiter.
module asc2hex
    import asc2hex_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [7:0]                    din,
    input  logic                          din_valid,
    output logic [WIDTH-1:0]              dout,
    output logic                          dout_valid,
    output logic                          ovf,
    output logic [$clog2(WIDTH/4+1)-1:0]  ndig,
    output logic                          err
);

    localparam int unsigned NDIG = WIDTH / 4;
    localparam int unsigned CW   = $clog2(NDIG + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_flag_q, ovf_flag_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]    ndig_q, ndig_d;
    logic             ovf_q, ovf_d;
    logic             dout_valid_q, dout_valid_d;
    logic             err_q, err_d;

    logic [3:0] nib;
    logic       is_hex;
    logic       is_delim;

    asc2nib u_asc2nib (
        .din      (din),
        .nib      (nib),
        .is_hex   (is_hex),
        .is_delim (is_delim)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_flag_q   <= 1'b0;
            dout_q       <= '0;
            ndig_q       <= '0;
            ovf_q        <= 1'b0;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_flag_q   <= ovf_flag_d;
            dout_q       <= dout_d;
            ndig_q       <= ndig_d;
            ovf_q        <= ovf_d;
            dout_valid_q <= dout_valid_d;
            err_q        <= err_d;
        end
    end

    // Shifting in at the bottom drops the oldest nibble, keeping the last NDIG digits.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_flag_d   = ovf_flag_q;
        dout_d       = dout_q;
        ndig_d       = ndig_q;
        ovf_d        = ovf_q;
        dout_valid_d = 1'b0;
        err_d        = 1'b0;
        if (din_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_hex) begin
                        acc_d      = WIDTH'(nib);
                        cnt_d      = CW'(1);
                        ovf_flag_d = 1'b0;
                        state_d    = ST_ACCUM;
                    end else if (!is_delim) begin
                        err_d   = 1'b1;
                        state_d = ST_SKIP;
                    end
                end
                ST_ACCUM: begin
                    if (is_hex) begin
                        acc_d = WIDTH'({acc_q, nib});
                        if (cnt_q == CW'(NDIG)) begin
                            ovf_flag_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (is_delim) begin
                        dout_d       = acc_q;
                        ndig_d       = cnt_q;
                        ovf_d        = ovf_flag_q;
                        dout_valid_d = 1'b1;
                        acc_d        = '0;
                        cnt_d        = '0;
                        ovf_flag_d   = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        err_d      = 1'b1;
                        acc_d      = '0;
                        cnt_d      = '0;
                        ovf_flag_d = 1'b0;
                        state_d    = ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (is_delim) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign ndig       = ndig_q;
    assign ovf        = ovf_q;
    assign dout_valid = dout_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_asc2hex.sv
// Directed bench for asc2hex at WIDTH=8, with a WIDTH=16 instance on the same stream.
module tb_asc2hex;

    logic        clk;
    logic        resetn;
    logic [7:0]  din;
    logic        din_valid;

    logic [7:0]  dout;
    logic        dout_valid;
    logic        ovf;
    logic [1:0]  ndig;
    logic        err;

    logic [15:0] w_dout;
    logic        w_dout_valid;
    logic        w_ovf;
    logic [2:0]  w_ndig;
    logic        w_err;

    int vectors;
    int miscompares;

    int          vcnt;
    int          ecnt;
    logic [7:0]  cap_q[$];
    logic [1:0]  cap_ndig;
    logic        cap_ovf;
    int          w_vcnt;
    logic [15:0] w_cap_dout;
    logic [2:0]  w_cap_ndig;
    logic        w_cap_ovf;

    asc2hex #(.WIDTH(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .ovf        (ovf),
        .ndig       (ndig),
        .err        (err)
    );

    asc2hex #(.WIDTH(16)) dut_w (
        .clk        (clk),
        .resetn     (resetn),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (w_dout),
        .dout_valid (w_dout_valid),
        .ovf        (w_ovf),
        .ndig       (w_ndig),
        .err        (w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            vcnt++;
            cap_q.push_back(dout);
            cap_ndig = ndig;
            cap_ovf  = ovf;
        end
        if (err === 1'b1) ecnt++;
        if (w_dout_valid === 1'b1) begin
            w_vcnt++;
            w_cap_dout = w_dout;
            w_cap_ndig = w_ndig;
            w_cap_ovf  = w_ovf;
        end
    end

    task automatic send_char(input logic [7:0] c);
        @(negedge clk);
        din       = c;
        din_valid = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din_valid = 1'b0;
            din       = 8'h00;
        end
    endtask

    task automatic clear_mon();
        @(negedge clk);
        vcnt   = 0;
        ecnt   = 0;
        w_vcnt = 0;
        cap_q.delete();
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({dout, ndig, ovf, dout_valid, err} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got dout=%h ndig=%0d ovf=%b dv=%b err=%b, want all 0",
                     dout, ndig, ovf, dout_valid, err);
        end
        resetn = 1'b1;
        idle(1);
    endtask

    task automatic test_basic();
        clear_mon();
        send_str("3F\n");
        @(negedge clk);
        din_valid = 1'b0;
        vectors++;
        if (dout_valid !== 1'b1 || dout !== 8'h3F || ndig !== 2'd2 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_3F: got dv=%b dout=%h ndig=%0d ovf=%b, want dv=1 dout=3f ndig=2 ovf=0",
                     dout_valid, dout, ndig, ovf);
        end
        @(negedge clk);
        vectors++;
        if (dout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_pulse_width: dout_valid=%b one cycle later, want 0", dout_valid);
        end
        idle(1);
        vectors++;
        if (vcnt != 1 || ecnt != 0) begin
            miscompares++;
            $display("FAIL basic_counts: got %0d valid %0d err, want 1 valid 0 err", vcnt, ecnt);
        end
        vectors++;
        if (w_vcnt != 1 || w_cap_dout !== 16'h003F || w_cap_ndig !== 3'd2) begin
            miscompares++;
            $display("FAIL basic_w16: got n=%0d dout=%h ndig=%0d, want n=1 dout=003f ndig=2",
                     w_vcnt, w_cap_dout, w_cap_ndig);
        end
    endtask

    task automatic test_single_and_delims();
        clear_mon();
        send_str("a");
        idle(2);
        send_str(" ");
        idle(2);
        vectors++;
        if (vcnt != 1 || cap_q.size() != 1 || cap_q[0] !== 8'h0A || cap_ndig !== 2'd1 || cap_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL single_a: got n=%0d dout=%h ndig=%0d ovf=%b, want n=1 dout=0a ndig=1 ovf=0",
                     vcnt, (cap_q.size() > 0) ? cap_q[0] : 8'hxx, cap_ndig, cap_ovf);
        end
        send_str("  ,\r");
        idle(3);
        vectors++;
        if (vcnt != 1 || ecnt != 0) begin
            miscompares++;
            $display("FAIL empty_tokens: got %0d valid %0d err, want 1 valid 0 err", vcnt, ecnt);
        end
        vectors++;
        if (dout !== 8'h0A || ndig !== 2'd1) begin
            miscompares++;
            $display("FAIL hold_after_delims: got dout=%h ndig=%0d, want 0a 1", dout, ndig);
        end
    endtask

    task automatic test_overflow();
        clear_mon();
        send_str("1234 ");
        idle(3);
        vectors++;
        if (vcnt != 1 || cap_q.size() != 1 || cap_q[0] !== 8'h34 || cap_ndig !== 2'd2 || cap_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_w8: got n=%0d dout=%h ndig=%0d ovf=%b, want n=1 dout=34 ndig=2 ovf=1",
                     vcnt, (cap_q.size() > 0) ? cap_q[0] : 8'hxx, cap_ndig, cap_ovf);
        end
        vectors++;
        if (w_vcnt != 1 || w_cap_dout !== 16'h1234 || w_cap_ndig !== 3'd4 || w_cap_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_w16: got n=%0d dout=%h ndig=%0d ovf=%b, want n=1 dout=1234 ndig=4 ovf=0",
                     w_vcnt, w_cap_dout, w_cap_ndig, w_cap_ovf);
        end
    endtask

    task automatic test_illegal();
        clear_mon();
        send_str("1G");
        @(negedge clk);
        din       = "5";
        din_valid = 1'b1;
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_timing: err=%b cycle after G, want 1", err);
        end
        send_str(" 7\n");
        idle(3);
        vectors++;
        if (ecnt != 1) begin
            miscompares++;
            $display("FAIL err_count: got %0d err cycles, want 1", ecnt);
        end
        vectors++;
        if (vcnt != 1 || cap_q.size() != 1 || cap_q[0] !== 8'h07 || cap_ndig !== 2'd1 || cap_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL after_skip: got n=%0d dout=%h ndig=%0d ovf=%b, want n=1 dout=07 ndig=1 ovf=0",
                     vcnt, (cap_q.size() > 0) ? cap_q[0] : 8'hxx, cap_ndig, cap_ovf);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_str("AB C\n");
        idle(3);
        vectors++;
        if (vcnt != 2 || cap_q.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d valid, want 2", vcnt);
        end else begin
            vectors++;
            if (cap_q[0] !== 8'hAB || cap_q[1] !== 8'h0C) begin
                miscompares++;
                $display("FAIL b2b_values: got %h,%h want ab,0c", cap_q[0], cap_q[1]);
            end
        end
        vectors++;
        if (ndig !== 2'd1 || ovf !== 1'b0 || ecnt != 0) begin
            miscompares++;
            $display("FAIL b2b_last: got ndig=%0d ovf=%b errs=%0d, want 1 0 0", ndig, ovf, ecnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_str("9");
        @(negedge clk);
        din_valid = 1'b0;
        resetn    = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        vectors++;
        if (dout !== 8'h00 || ndig !== 2'd0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_clear: got dout=%h ndig=%0d ovf=%b, want 0 0 0", dout, ndig, ovf);
        end
        send_str("\n");
        idle(3);
        vectors++;
        if (vcnt != 0 || w_vcnt != 0) begin
            miscompares++;
            $display("FAIL mid_reset_token: got %0d/%0d valid, want 0/0", vcnt, w_vcnt);
        end
        vectors++;
        if (dout !== 8'h00 || ndig !== 2'd0 || ovf !== 1'b0 || ecnt != 0) begin
            miscompares++;
            $display("FAIL mid_reset_hold: got dout=%h ndig=%0d ovf=%b errs=%0d, want 0 0 0 0",
                     dout, ndig, ovf, ecnt);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        vcnt        = 0;
        ecnt        = 0;
        w_vcnt      = 0;
        resetn      = 1'b0;
        din         = 8'h00;
        din_valid   = 1'b0;
        test_reset();
        test_basic();
        test_single_and_delims();
        test_overflow();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/asc2hex.md
Name: asc2hex

Overview:
- Inverse of the nibble-to-ASCII hex path: parses a stream of ASCII characters and accumulates hexadecimal digits into a WIDTH-bit binary value.
- A delimiter character ends a token. The block then presents the value with a one-cycle valid strobe.
- Sits between a character source (UART RX, keyboard/console input) and command/register logic in the font/console design.

Parameters:
- WIDTH, 8, accumulator/output width in bits; must be a multiple of 4, minimum 4.
- NDIG, WIDTH/4, derived localparam: number of hex digits that fit in WIDTH. Not overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  synchronous, active-low reset.
- din  input  8  ASCII character.
- din_valid  input  1  one-cycle strobe; din is sampled when high.
- dout  output  WIDTH  parsed value; held stable between tokens.
- dout_valid  output  1  one-cycle pulse when a token completes.
- ovf  output  1  qualifies dout_valid: token had more than NDIG digits.
- ndig  output  $clog2(NDIG+1)  number of digits in the token, saturating at NDIG; qualifies dout_valid.
- err  output  1  one-cycle pulse on an illegal character.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE; accumulator, dout, ndig=0; dout_valid, err, ovf=0.
  - din_valid is ignored while resetn=0.
- Character classes (pure function of din):
  - HEX: '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66).
  - DELIM: space 0x20, CR 0x0D, LF 0x0A, ',' 0x2C.
  - ILLEGAL: everything else.
- Digit accumulation: acc <= {acc[WIDTH-5:0], nib}. The upper nibble is discarded, so the result is always the last NDIG digits.
- Digit counter: increments per HEX char, saturating at NDIG. A HEX char arriving when the count is already NDIG sets the internal ovf_flag.
- State machine, transitions only on din_valid=1:
  - IDLE:
    - HEX: acc={0,nib}, cnt=1 -> ACCUM.
    - DELIM: stay IDLE; no output. Empty tokens are never emitted.
    - ILLEGAL: err pulse -> SKIP.
  - ACCUM:
    - HEX: shift in nibble, update cnt/ovf_flag, stay.
    - DELIM: next cycle dout<=acc, ndig<=cnt, ovf<=ovf_flag, dout_valid=1; clear acc/cnt/ovf_flag -> IDLE.
    - ILLEGAL: err pulse; discard acc -> SKIP.
  - SKIP:
    - DELIM: -> IDLE with no output.
    - HEX or ILLEGAL: stay; no further err pulses.
- Latency:
  - Delimiter sampled at edge N -> dout_valid high during cycle N..N+1, i.e. registered, exactly 1 cycle wide.
  - err is registered with the same timing.
- dout, ndig, ovf hold their values until the next dout_valid.
- Back-to-back din_valid on consecutive cycles must be accepted at full rate, including a delimiter followed immediately by a digit of the next token.
- din_valid=0: state, acc and all outputs hold; pulses deassert.
- Reset mid-token: partial token discarded; no dout_valid.

Decomposition:
- Shared const.vh gets ASCII constants: ASCII_0, ASCII_9, ASCII_UA, ASCII_UF, ASCII_LA, ASCII_LF, ASCII_SP, ASCII_CR, ASCII_NL, ASCII_COMMA.
- Shared const.vh also gets the state encodings ST_IDLE, ST_ACCUM, ST_SKIP.
- One combinational sub-module, asc2nib: din[7:0] -> nib[3:0], is_hex, is_delim. It is reusable by other console parsers.
- asc2hex holds the FSM, accumulator and output registers.

Test Plan (WIDTH=8 unless noted):
- "3F\n": dout=0x3F, ndig=2, ovf=0, one dout_valid pulse one cycle after the LF strobe, err never high.
- "a" then " ": dout=0x0A, ndig=1. Consecutive delimiters "  ,\r" give no dout_valid.
- "1234 ": dout=0x34, ndig=2, ovf=1. Same input with WIDTH=16 gives dout=0x1234, ovf=0.
- "1G5 7\n": one err pulse on 'G', no pulse on '5' or ' ' in SKIP, then dout=0x07.
- "AB" with din_valid on every cycle, followed immediately by " C\n": two dout_valid pulses, 0xAB then 0x0C, no dropped characters.
- "9" then resetn=0 for one cycle then "\n": no dout_valid; dout/ndig/ovf read 0 after reset.
